// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, divider computation, frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // Start + 8 data + stop.
  localparam int FRAME_LEN = 10;
  localparam int DATA_BITS = 8;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled, held at 0 otherwise,
// and pulses tick for one cycle in the last cycle of each bit period.
module baud_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and wrap tick.
  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (enable) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered TxD and one-cycle accept latency.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: CLK_FREQ/BAUD must round to at least 2");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        tick;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q != S_IDLE),
    .tick   (tick)
  );

  // Next-state, shift and line-level logic; TxD follows the next state.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (TxD_start) begin
          state_d = S_START;
          sh_d    = TxD_data;
          bit_d   = 3'd0;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          txd_d   = sh_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = 3'd0;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign TxD      = txd_q;
  assign TxD_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=16 (CLK_FREQ=1600, BAUD=100).
module tb_uart_tx;

  localparam int DIV = 16;
  localparam int FRAME_CYC = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       TxD_start = 1'b0;
  logic [7:0] TxD_data = 8'h00;
  logic       TxD;
  logic       TxD_busy;

  int errors = 0;
  int checks = 0;

  uart_tx #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data),
    .TxD       (TxD),
    .TxD_busy  (TxD_busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one cycle after acceptance; checks ncyc cycles of the frame.
  // At cycle poke_at+1 a competing request with 0x3C is pulsed for one cycle.
  task automatic check_frame(input logic [7:0] b, input int poke_at, input int ncyc);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      if (k == poke_at) begin
        TxD_start = 1'b1;
        TxD_data  = 8'h3C;
      end
      if (k == poke_at + 1) TxD_start = 1'b0;
      chk($sformatf("txd byte=%02h cyc=%0d", b, k + 1), {31'd0, TxD}, {31'd0, fr[k / DIV]});
      chk($sformatf("busy byte=%02h cyc=%0d", b, k + 1), {31'd0, TxD_busy}, 32'd1);
      step();
    end
  endtask

  task automatic check_idle(input string tag, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      chk($sformatf("%s txd idle %0d", tag, k), {31'd0, TxD}, 32'd1);
      chk($sformatf("%s busy idle %0d", tag, k), {31'd0, TxD_busy}, 32'd0);
      step();
    end
  endtask

  task automatic send_pulse(input logic [7:0] b);
    TxD_data  = b;
    TxD_start = 1'b1;
    step();
    TxD_start = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;

    // Reset state
    rst = 1'b1;
    step(); step(); step();
    chk("reset txd", {31'd0, TxD}, 32'd1);
    chk("reset busy", {31'd0, TxD_busy}, 32'd0);
    rst = 1'b0;
    check_idle("post-reset", 3);

    // 0xA5 single frame: 0 | 1 0 1 0 0 1 0 1 | 1
    send_pulse(8'hA5);
    check_frame(8'hA5, -10, FRAME_CYC);
    check_idle("after A5", 4);

    // Back-to-back with start held: 0x00 then 0xFF, data changed mid-frame
    TxD_data  = 8'h00;
    TxD_start = 1'b1;
    step();
    TxD_data  = 8'hFF;
    check_frame(8'h00, -10, FRAME_CYC);
    // single idle cycle between frames
    chk("b2b gap txd", {31'd0, TxD}, 32'd1);
    chk("b2b gap busy", {31'd0, TxD_busy}, 32'd0);
    step();
    TxD_start = 1'b0;
    check_frame(8'hFF, -10, FRAME_CYC);
    check_idle("after FF", 4);

    // Request while busy at cycle 40 is ignored, no extra frame
    send_pulse(8'h5A);
    check_frame(8'h5A, 39, FRAME_CYC);
    check_idle("after ignored req", 2 * DIV);

    // Reset at cycle 70 aborts the frame
    send_pulse(8'hC3);
    check_frame(8'hC3, -10, 69);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort", 4);
    send_pulse(8'h96);
    check_frame(8'h96, -10, FRAME_CYC);
    check_idle("after 96", 4);

    // rst and start in the same cycle: request dropped
    TxD_data  = 8'h0F;
    TxD_start = 1'b1;
    rst       = 1'b1;
    step();
    TxD_start = 1'b0;
    rst       = 1'b0;
    check_idle("rst-vs-start", 2 * DIV);

    // A few random bytes
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_pulse(rb);
      check_frame(rb, -10, FRAME_CYC);
      check_idle("rand", 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, shall set the clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, shall set the line rate in bit/s.
REQ-003 clk  input  1  shall be the single clock; all logic samples on its rising edge.
REQ-004 rst  input  1  shall be the reset, synchronous and active-high.
REQ-005 TxD_start  input  1  shall be a request to send TxD_data, sampled each cycle.
REQ-006 TxD_data  input  8  shall be the byte to send, captured only when a request is accepted.
REQ-007 TxD  output  1  shall be the serial line, idle high, driven from a register.
REQ-008 TxD_busy  output  1  shall be high while a frame is in progress.

Function
REQ-009 DIV shall equal CLK_FREQ/BAUD, rounded to nearest; elaboration shall fail if DIV < 2.
REQ-010 Frame format shall be 8N1: start bit 0, data bits d0..d7 LSB first, one stop bit 1.
REQ-011 A request shall be accepted in any cycle where TxD_start=1 and the FSM is in IDLE; TxD_data shall be latched into a shift register in that cycle.
REQ-012 FSM states shall be IDLE, START, DATA, STOP; transitions IDLE->START on accept, START->DATA after DIV cycles, DATA->STOP after 8 bit periods, STOP->IDLE after DIV cycles.
REQ-013 TxD shall go low on the first cycle after acceptance (1-cycle latency).
REQ-014 Every bit, including start and stop, shall hold on TxD for exactly DIV clock cycles.
REQ-015 TxD_busy shall be high from the cycle after acceptance through the last stop-bit cycle, and low in IDLE.
REQ-016 TxD_start while busy shall be ignored without side effects; TxD_data changes during a frame shall not affect the frame.
REQ-017 A request held high across a frame end shall be accepted in the first IDLE cycle, giving a back-to-back frame period of 10*DIV+1 cycles.
REQ-018 The bit-period counter shall be ceil(log2(DIV)) bits wide, count 0..DIV-1, and wrap to 0 at the end of each bit; the bit index counter shall count 0..7.
REQ-019 The bit-period counter shall be held at 0 in IDLE so each frame starts phase-aligned to acceptance.

Reset
REQ-020 On rst=1 at a clock edge, the FSM shall enter IDLE, TxD shall be 1, TxD_busy shall be 0, and counters and the shift register shall be 0.
REQ-021 Reset asserted mid-frame shall abort the frame; TxD shall read 1 from the next cycle; no partial frame shall resume.
REQ-022 rst shall dominate TxD_start in the same cycle; the request shall be dropped.

Structure
REQ-023 The FSM state encoding, the DIV computation function, and the frame-length constant (10) shall live in a shared package uart_pkg, reused by the receiver.
REQ-024 The bit-period counter shall be one sub-module, baud_tick_gen, with inputs clk, rst, and enable, and a one-cycle tick output at counter wrap.

Verification
REQ-025 CLK_FREQ=1600, BAUD=100 (DIV=16): pulse TxD_start with 0xA5 -> TxD low cycles 1-16, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, high 16 cycles; busy high for 160 cycles.
REQ-026 Hold TxD_start high with 0x00 then 0xFF -> second start bit begins exactly 161 cycles after the first; no idle gap beyond 1 cycle.
REQ-027 Pulse TxD_start with 0x3C at cycle 40 of a frame in progress -> frame unchanged; no extra frame follows.
REQ-028 Assert rst at cycle 70 of a frame -> TxD=1 and busy=0 the next cycle; a new request 5 cycles later yields a clean full frame.
REQ-029 rst and TxD_start both high in the same cycle -> no frame; TxD stays 1 and busy stays 0.
REQ-030 Loopback to the team receiver at default parameters, 256 random bytes -> all bytes received in order with no framing errors.
